output_display_module: RTL
==========================

// Module: output_display_module
//
// PURPOSE
// Output stage downstream of control_module. It consumes the OUI control bit and the 8-bit bus.
// On OUI it latches the bus byte and converts it to BCD with a sequential double-dabble engine.
// The result drives a 4-digit multiplexed 7-segment display: unsigned 0..255 or signed -128..127.
//
// PARAMETERS
// REFRESH_DIV     16'd50000  clk cycles each digit is enabled before the scan advances (>=2)
// SEG_ACTIVE_LOW  0          1 = invert seg and an at the pins; tests below assume 0
//
// PORTS
// clk          in   1  system clock; all logic on posedge
// rst          in   1  synchronous reset, active-high
// bus          in   8  CPU data bus
// oui          in   1  output-register-in control bit (ctrl[OUI])
// signed_mode  in   1  1 = two's-complement display; sampled with oui
// out_value    out  8  raw latched output byte
// busy         out  1  conversion in progress
// seg          out  7  segments {g,f,e,d,c,b,a}, active-high
// an           out  4  digit enables, one-hot, active-high, an[0] = ones
//
// BEHAVIOUR
// - Reset (rst=1 at an edge): all state is cleared.
//   - out_value=0, busy=0.
//   - Display registers show "   0".
//   - Scan index=0, refresh counter=0.
//   - Outputs: an=4'b0001, seg=7'h3F. Reset overrides oui in the same cycle.
// - Capture (edge E with oui=1):
//   - out_value<=bus.
//   - sgn<=signed_mode&bus[7].
//   - mag<= sgn ? -bus : bus, computed at 9 bits; 8'h80 signed gives 128.
//   - FSM enters SHIFT; busy=1 from E+1.
// - FSM states and transitions:
//   - IDLE -(oui)-> SHIFT.
//   - SHIFT: 8 edges; each edge adds 3 to every BCD nibble >=5, then shifts {bcd[11:0],mag} left by 1.
//   - SHIFT -(8th shift)-> COMMIT.
//   - COMMIT: hundreds/tens/ones/sign are copied to display registers atomically, FSM returns to IDLE, busy=0 after this edge.
// - Timing: capture at E, shifts at E+1..E+8, commit at E+9. The new digits are visible from E+9.
// - oui while busy: the new byte is captured and the conversion restarts from the first shift (latest wins). The old value is never committed.
// - Display registers change only at COMMIT. The scan is never disturbed by conversion.
// - Digit content:
//   - Digit3 is '-' (7'h40) if sgn, else blank (7'h00).
//   - Hundreds digit is blank if 0.
//   - Tens digit is blank if 0 and hundreds is 0.
//   - Ones digit is always shown.
// - 7-segment codes for 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
// - Scan:
//   - The counter counts 0..REFRESH_DIV-1.
//   - On wrap the index advances 0->1->2->3->0 and the counter returns to 0.
//   - an=1<<index. seg decodes the digit selected by the current index, so there is no cross-digit glitch.
// - seg/an are combinational from registers only. With SEG_ACTIVE_LOW=1 both are inverted, and reset values invert too.
// - Reset mid-conversion: the conversion is aborted with no commit, and all reset values are restored on that edge.
//
// TESTING (REFRESH_DIV=4)
// 1. Reset 3 cycles.
//    -> an=0001, seg=3F, busy=0, out_value=00.
//    -> Scan reaches an=0010 after 4 cycles and seg=00 there.
// 2. bus=8'd123, oui=1 for 1 cycle, unsigned.
//    -> busy=1 for exactly 9 cycles.
//    -> Scan shows digit2=06, digit1=5B, digit0=4F, digit3=00.
// 3. signed_mode=1 with 8'hFF -> "-  1" (40,00,00,06).
//    signed 8'h80 -> "-128".
//    unsigned 8'hFF -> " 255".
// 4. oui with 200, then oui with 7 three cycles later.
//    -> 200 is never displayed.
//    -> "   7" is committed 9 cycles after the second oui.
// 5. Value 0 -> "   0".
//    Value 100 -> " 100" (interior zeros shown).
//    Value 5 -> "   5".
// 6. oui with 99, then rst at the 4th SHIFT cycle.
//    -> Reset values are shown and busy=0.
//    -> No commit occurs afterwards.

Source files
------------

// File: rtl/output_display_module.sv
// Output register stage: latches the CPU bus byte on OUI, converts it to BCD with a
// sequential double-dabble engine and drives a 4-digit multiplexed 7-segment display.
module output_display_module #(
    parameter logic [15:0] REFRESH_DIV    = 16'd50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus,
    input  logic       oui,
    input  logic       signed_mode,
    output logic [7:0] out_value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  shift_cnt_q, shift_cnt_d;
    logic [19:0] dd_q, dd_d;          // {hundreds, tens, ones, magnitude}
    logic [19:0] dd_adj;
    logic        sgn_q, sgn_d;
    logic [7:0]  out_value_q, out_value_d;
    logic        disp_sgn_q, disp_sgn_d;
    logic [3:0]  disp_h_q, disp_h_d;
    logic [3:0]  disp_t_q, disp_t_d;
    logic [3:0]  disp_o_q, disp_o_d;
    logic [15:0] ref_cnt_q;
    logic [1:0]  scan_idx_q;
    logic        sgn_cap;
    logic [7:0]  mag_cap;
    logic [6:0]  seg_raw;

    // Negating in 8 bits is enough: -8'h80 wraps to 8'h80, which reads as 128 unsigned.
    assign sgn_cap = signed_mode & bus[7];
    assign mag_cap = sgn_cap ? (8'd0 - bus) : bus;

    always_comb begin
        dd_adj = dd_q;
        for (int i = 0; i < 3; i++) begin
            if (dd_q[8 + 4*i +: 4] >= 4'd5) begin
                dd_adj[8 + 4*i +: 4] = dd_q[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        dd_d        = dd_q;
        sgn_d       = sgn_q;
        out_value_d = out_value_q;
        disp_sgn_d  = disp_sgn_q;
        disp_h_d    = disp_h_q;
        disp_t_d    = disp_t_q;
        disp_o_d    = disp_o_q;
        // A capture in any state restarts the conversion, so a pending value is dropped.
        if (oui) begin
            out_value_d = bus;
            sgn_d       = sgn_cap;
            dd_d        = {12'd0, mag_cap};
            shift_cnt_d = 3'd0;
            state_d     = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    dd_d        = dd_adj << 1;
                    shift_cnt_d = shift_cnt_q + 3'd1;
                    if (shift_cnt_q == 3'd7) begin
                        state_d = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_sgn_d = sgn_q;
                    disp_h_d   = dd_q[19:16];
                    disp_t_d   = dd_q[15:12];
                    disp_o_d   = dd_q[11:8];
                    state_d    = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= 3'd0;
            dd_q        <= 20'd0;
            sgn_q       <= 1'b0;
            out_value_q <= 8'd0;
            disp_sgn_q  <= 1'b0;
            disp_h_q    <= 4'd0;
            disp_t_q    <= 4'd0;
            disp_o_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            dd_q        <= dd_d;
            sgn_q       <= sgn_d;
            out_value_q <= out_value_d;
            disp_sgn_q  <= disp_sgn_d;
            disp_h_q    <= disp_h_d;
            disp_t_q    <= disp_t_d;
            disp_o_q    <= disp_o_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q  <= 16'd0;
            scan_idx_q <= 2'd0;
        end else if (ref_cnt_q == REFRESH_DIV - 16'd1) begin
            ref_cnt_q  <= 16'd0;
            scan_idx_q <= scan_idx_q + 2'd1;
        end else begin
            ref_cnt_q  <= ref_cnt_q + 16'd1;
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    // Leading-zero blanking: tens is blank only when hundreds is blank too.
    always_comb begin
        seg_raw = 7'h00;
        case (scan_idx_q)
            2'd0: seg_raw = seg_code(disp_o_q);
            2'd1: seg_raw = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? 7'h00 : seg_code(disp_t_q);
            2'd2: seg_raw = (disp_h_q == 4'd0) ? 7'h00 : seg_code(disp_h_q);
            2'd3: seg_raw = disp_sgn_q ? 7'h40 : 7'h00;
            default: seg_raw = 7'h00;
        endcase
    end

    assign seg         = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign an          = SEG_ACTIVE_LOW ? ~(4'b0001 << scan_idx_q) : (4'b0001 << scan_idx_q);
    assign out_value   = out_value_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule
